// File: rtl/sprite_position_ctrl.sv
// Bounding-box controller for one scalable sprite: synchronised button requests with auto-repeat,
// applied once per frame with clamp or wrap-around at the screen edges.
module sprite_position_ctrl #(
  parameter  int H_RES        = 640,
  parameter  int V_RES        = 480,
  parameter  int BASE_W       = 8,
  parameter  int BASE_H       = 16,
  parameter  int STEP_X       = 8,
  parameter  int STEP_Y       = 16,
  parameter  int WRAP_MODE    = 0,
  parameter  int REPEAT_DELAY = 30,
  parameter  int REPEAT_RATE  = 4,
  localparam int HW           = $clog2(H_RES),
  localparam int VW           = $clog2(V_RES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    moveReq,
  input  logic          center,
  input  logic [2:0]    charSize,
  input  logic          frameTick,
  output logic [HW-1:0] posHorStart,
  output logic [HW-1:0] posHorEnd,
  output logic [VW-1:0] posVerStart,
  output logic [VW-1:0] posVerEnd,
  output logic [3:0]    edgeHit
);

  localparam int DIR_U = 0;
  localparam int DIR_D = 1;
  localparam int DIR_L = 2;
  localparam int DIR_R = 3;

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW  = $clog2(RMAX + 1);
  localparam int X0   = (H_RES - BASE_W) / 2;
  localparam int Y0   = (V_RES - BASE_H) / 2;

  // One axis of the per-frame update: recentre, step with clamp/wrap, then keep the box on screen.
  function automatic int axis_next(input int pos, input int len, input int step, input int res,
                                   input logic ctr, input logic dec, input logic inc,
                                   output logic hit_dec, output logic hit_inc);
    int p;
    hit_dec = 1'b0;
    hit_inc = 1'b0;
    p       = pos;
    if (ctr) begin
      p = (res - len) >> 1;
    end else if (dec && !inc) begin
      if (WRAP_MODE != 0)  p = (pos < step) ? pos + res - step : pos - step;
      else if (pos < step) begin
        p       = 0;
        hit_dec = 1'b1;
      end else             p = pos - step;
    end else if (inc && !dec) begin
      if (WRAP_MODE != 0)                p = (pos + step >= res) ? pos + step - res : pos + step;
      else if (pos + step > res - len) begin
        p       = res - len;
        hit_inc = 1'b1;
      end else                           p = pos + step;
    end
    if (WRAP_MODE == 0 && p > res - len) p = res - len;
    return p;
  endfunction

  function automatic int axis_end(input int start, input int len, input int res);
    int e;
    e = start + len - 1;
    return (e >= res) ? e - res : e;
  endfunction

  logic [3:0]     meta, lvl, prev, armed, held, pending;
  logic [1:0]     settle;
  logic           center_pend;
  logic [RCW-1:0] rep_cnt [4];
  logic [3:0]     rep_phase;
  logic [3:0]     press, due, eff;

  // A press is only accepted once the button has been seen released since reset.
  assign press = lvl & ~prev & armed;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    due = '0;
    for (int d = 0; d < 4; d++) begin
      if (REPEAT_DELAY != 0 && held[d]) begin
        if (rep_phase[d]) due[d] = (int'(rep_cnt[d]) == REPEAT_RATE);
        else              due[d] = (int'(rep_cnt[d]) == REPEAT_DELAY);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta        <= '0;
      lvl         <= '0;
      prev        <= '0;
      armed       <= '0;
      held        <= '0;
      pending     <= '0;
      settle      <= '0;
      center_pend <= 1'b0;
      rep_phase   <= '0;
      // NOTE: the repeat counters are a small register array, so they are reset like any other state.
      for (int d = 0; d < 4; d++) rep_cnt[d] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop here sample pre-edge values (proper pipeline).
      meta        <= moveReq;
      lvl         <= meta;
      prev        <= lvl;
      settle      <= {settle[0], 1'b1};
      armed       <= armed | (~lvl & {4{settle[1]}});
      held        <= (held | press) & lvl;
      pending     <= frameTick ? 4'b0 : (pending | press);
      center_pend <= !frameTick && (center_pend || center);
      for (int d = 0; d < 4; d++) begin
        if (press[d]) begin
          rep_cnt[d]   <= frameTick ? RCW'(1) : '0;
          rep_phase[d] <= 1'b0;
        end else if (!lvl[d]) begin
          rep_cnt[d]   <= '0;
          rep_phase[d] <= 1'b0;
        end else if (frameTick && held[d] && REPEAT_DELAY != 0) begin
          if (due[d]) begin
            rep_cnt[d]   <= RCW'(1);
            rep_phase[d] <= 1'b1;
          end else begin
            rep_cnt[d]   <= rep_cnt[d] + RCW'(1);
          end
        end
      end
    end
  end

  logic ctr, hit_u, hit_d, hit_l, hit_r;
  int   w, h, nx, ny, nxe, nye;

  always_comb begin
    eff   = pending | press | due;
    ctr   = center_pend | center;
    w     = BASE_W * (int'(charSize) + 1);
    h     = BASE_H * (int'(charSize) + 1);
    hit_u = 1'b0;
    hit_d = 1'b0;
    hit_l = 1'b0;
    hit_r = 1'b0;
    nx    = axis_next(int'(posHorStart), w, STEP_X, H_RES, ctr, eff[DIR_L], eff[DIR_R], hit_l, hit_r);
    ny    = axis_next(int'(posVerStart), h, STEP_Y, V_RES, ctr, eff[DIR_U], eff[DIR_D], hit_u, hit_d);
    nxe   = axis_end(nx, w, H_RES);
    nye   = axis_end(ny, h, V_RES);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      posHorStart <= HW'(X0);
      posHorEnd   <= HW'(X0 + BASE_W - 1);
      posVerStart <= VW'(Y0);
      posVerEnd   <= VW'(Y0 + BASE_H - 1);
      edgeHit     <= '0;
    end else if (frameTick) begin
      posHorStart <= HW'(nx);
      posHorEnd   <= HW'(nxe);
      posVerStart <= VW'(ny);
      posVerEnd   <= VW'(nye);
      edgeHit     <= {hit_r, hit_l, hit_d, hit_u};
    end else begin
      edgeHit     <= '0;
    end
  end

endmodule

// File: tb/tb_sprite_position_ctrl.sv
// Bench for sprite_position_ctrl: clamp, wrap and fine-step instances share one stimulus stream;
// directed table, corner-case sequences, then random frames against a frame-level model.
module tb_sprite_position_ctrl;

  localparam int H = 640, V = 480, BW = 8, BH = 16, DLY = 30, RATE = 4;

  logic       clk = 1'b0, reset = 1'b0, center = 1'b0, frameTick = 1'b0;
  logic [3:0] moveReq = '0;
  logic [2:0] charSize = '0;
  logic [9:0] c_hs, c_he, w_hs, w_he, s_hs, s_he;
  logic [8:0] c_vs, c_ve, w_vs, w_ve, s_vs, s_ve;
  logic [3:0] c_eh, w_eh, s_eh;

  always #5 clk = ~clk;

  sprite_position_ctrl dut_c (
    .clk(clk), .reset(reset), .moveReq(moveReq), .center(center), .charSize(charSize),
    .frameTick(frameTick), .posHorStart(c_hs), .posHorEnd(c_he), .posVerStart(c_vs),
    .posVerEnd(c_ve), .edgeHit(c_eh));

  sprite_position_ctrl #(.WRAP_MODE(1)) dut_w (
    .clk(clk), .reset(reset), .moveReq(moveReq), .center(center), .charSize(charSize),
    .frameTick(frameTick), .posHorStart(w_hs), .posHorEnd(w_he), .posVerStart(w_vs),
    .posVerEnd(w_ve), .edgeHit(w_eh));

  sprite_position_ctrl #(.STEP_Y(1)) dut_s (
    .clk(clk), .reset(reset), .moveReq(moveReq), .center(center), .charSize(charSize),
    .frameTick(frameTick), .posHorStart(s_hs), .posHorEnd(s_he), .posVerStart(s_vs),
    .posVerEnd(s_ve), .edgeHit(s_eh));

  int n_checks = 0;
  int n_err    = 0;

  function automatic logic [63:0] pk(input int hs, input int he, input int vs, input int ve, input int e);
    return {16'(hs), 16'(he), 16'(vs), 12'(ve), 4'(e)};
  endfunction

  function automatic logic [63:0] got(input int i);
    case (i)
      0:       return pk(int'(c_hs), int'(c_he), int'(c_vs), int'(c_ve), int'(c_eh));
      1:       return pk(int'(w_hs), int'(w_he), int'(w_vs), int'(w_ve), int'(w_eh));
      default: return pk(int'(s_hs), int'(s_he), int'(s_vs), int'(s_ve), int'(s_eh));
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got hor %0d/%0d ver %0d/%0d edge %b, expected hor %0d/%0d ver %0d/%0d edge %b",
               name, act[63:48], act[47:32], act[31:16], act[15:4], act[3:0],
               exp[63:48], exp[47:32], exp[31:16], exp[15:4], exp[3:0]);
    end
  endtask

  task automatic tick();
    @(negedge clk) frameTick = 1'b1;
    @(negedge clk) frameTick = 1'b0;
  endtask

  task automatic set_lvl(input logic [3:0] l);
    @(negedge clk) moveReq = l;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] l);
    set_lvl(l);
    set_lvl(4'b0000);
  endtask

  task automatic pulse_center();
    @(negedge clk) center = 1'b1;
    @(negedge clk) center = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Frame-level reference model: button history per direction, three position models.
  typedef struct {int sx; int sy; bit wrap; int x; int y; int ex; int ey; int hit;} mdl_t;
  mdl_t     m [3];
  bit [3:0] m_lvl, m_armed, m_held, m_pend;
  int       m_k [4];
  bit       m_ctr;

  function automatic void model_init();
    m[0] = '{8, 16, 1'b0, 316, 232, 323, 247, 0};
    m[1] = '{8, 16, 1'b1, 316, 232, 323, 247, 0};
    m[2] = '{8, 1,  1'b0, 316, 232, 323, 247, 0};
    m_lvl = '0; m_armed = '1; m_held = '0; m_pend = '0; m_ctr = 1'b0;
    for (int d = 0; d < 4; d++) m_k[d] = 0;
  endfunction

  function automatic void model_level(input logic [3:0] nl);
    for (int d = 0; d < 4; d++) begin
      if (nl[d] && !m_lvl[d] && m_armed[d]) begin
        m_pend[d] = 1'b1;
        m_held[d] = 1'b1;
        m_k[d]    = 0;
      end
      if (!nl[d]) begin
        m_held[d]  = 1'b0;
        m_armed[d] = 1'b1;
      end
    end
    m_lvl = nl;
  endfunction

  function automatic void model_tick();
    bit [3:0] eff;
    int       w, h, x, y, hit;
    for (int d = 0; d < 4; d++) begin
      eff[d] = m_pend[d];
      if (m_held[d]) begin
        m_k[d]++;
        if (m_k[d] - 1 >= DLY && (m_k[d] - 1 - DLY) % RATE == 0) eff[d] = 1'b1;
      end
    end
    w = BW * (int'(charSize) + 1);
    h = BH * (int'(charSize) + 1);
    for (int i = 0; i < 3; i++) begin
      x = m[i].x; y = m[i].y; hit = 0;
      if (m_ctr) begin
        x = (H - w) / 2;
        y = (V - h) / 2;
      end else begin
        if (eff[2] && !eff[3]) begin
          if (m[i].wrap)        x = (x + H - m[i].sx) % H;
          else if (x < m[i].sx) begin x = 0; hit += 4; end
          else                  x -= m[i].sx;
        end
        if (eff[3] && !eff[2]) begin
          if (m[i].wrap)                  x = (x + m[i].sx) % H;
          else if (x + m[i].sx > H - w)   begin x = H - w; hit += 8; end
          else                            x += m[i].sx;
        end
        if (eff[0] && !eff[1]) begin
          if (m[i].wrap)        y = (y + V - m[i].sy) % V;
          else if (y < m[i].sy) begin y = 0; hit += 1; end
          else                  y -= m[i].sy;
        end
        if (eff[1] && !eff[0]) begin
          if (m[i].wrap)                  y = (y + m[i].sy) % V;
          else if (y + m[i].sy > V - h)   begin y = V - h; hit += 2; end
          else                            y += m[i].sy;
        end
      end
      if (!m[i].wrap && x > H - w) x = H - w;
      if (!m[i].wrap && y > V - h) y = V - h;
      m[i].x = x; m[i].y = y; m[i].hit = hit;
      m[i].ex = (x + w - 1) % H;
      m[i].ey = (y + h - 1) % V;
    end
    m_pend = '0;
    m_ctr  = 1'b0;
  endfunction

  typedef struct {logic [3:0] mv; bit ctr; int sz; int hs; int he; int vs; int ve;} vec_t;
  vec_t tbl [12];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, limit 3000000 reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b0100, 1'b0, 0, 308, 315, 232, 247};
    tbl[1]  = '{4'b0000, 1'b0, 0, 308, 315, 232, 247};
    tbl[2]  = '{4'b1100, 1'b0, 0, 308, 315, 232, 247};
    tbl[3]  = '{4'b0001, 1'b1, 0, 316, 323, 232, 247};
    tbl[4]  = '{4'b0000, 1'b0, 1, 316, 331, 232, 263};
    tbl[5]  = '{4'b0001, 1'b0, 1, 316, 331, 216, 247};
    tbl[6]  = '{4'b0010, 1'b0, 1, 316, 331, 232, 263};
    tbl[7]  = '{4'b1000, 1'b0, 0, 324, 331, 232, 247};
    tbl[8]  = '{4'b0000, 1'b1, 7, 288, 351, 176, 303};
    tbl[9]  = '{4'b0111, 1'b0, 7, 280, 343, 176, 303};
    tbl[10] = '{4'b0000, 1'b1, 0, 316, 323, 232, 247};
    tbl[11] = '{4'b1010, 1'b0, 0, 324, 331, 248, 263};

    do_reset();
    for (int i = 0; i < 3; i++) check($sformatf("reset_%0d", i), got(i), pk(316, 323, 232, 247, 0));

    pulse(4'b0100);
    repeat (20) @(negedge clk);
    check("no_tick_hold", got(0), pk(316, 323, 232, 247, 0));

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].mv != 4'b0000) pulse(tbl[i].mv);
      if (tbl[i].ctr) pulse_center();
      charSize = 3'(tbl[i].sz);
      tick();
      check($sformatf("tbl%0d_clamp", i), got(0), pk(tbl[i].hs, tbl[i].he, tbl[i].vs, tbl[i].ve, 0));
      check($sformatf("tbl%0d_wrap", i),  got(1), pk(tbl[i].hs, tbl[i].he, tbl[i].vs, tbl[i].ve, 0));
    end

    // Walk to x=4, y=8, then push past the left/top edges.
    charSize = 3'd0;
    do_reset();
    for (int f = 1; f <= 39; f++) begin
      pulse((f <= 14) ? 4'b0101 : 4'b0100);
      tick();
    end
    check("walk_clamp", got(0), pk(4, 11, 8, 23, 0));
    check("walk_wrap",  got(1), pk(4, 11, 8, 23, 0));
    check("walk_fine",  got(2), pk(4, 11, 218, 233, 0));
    pulse(4'b0101);
    tick();
    check("edge_clamp", got(0), pk(0, 7, 0, 15, 4'b0101));
    check("edge_wrap",  got(1), pk(636, 3, 472, 7, 0));
    check("edge_fine",  got(2), pk(0, 7, 217, 232, 4'b0100));
    @(negedge clk);
    check("edge_pulse_end", got(0), pk(0, 7, 0, 15, 0));
    pulse(4'b0100);
    tick();
    check("edge_again_clamp", got(0), pk(0, 7, 0, 15, 4'b0100));
    check("edge_again_wrap",  got(1), pk(628, 635, 472, 7, 0));
    check("edge_again_fine",  got(2), pk(0, 7, 217, 232, 4'b0100));

    // Right edge, then grow the sprite while pinned against it.
    do_reset();
    for (int f = 1; f <= 40; f++) begin
      pulse(4'b1000);
      tick();
    end
    check("right_clamp", got(0), pk(632, 639, 232, 247, 4'b1000));
    check("right_wrap",  got(1), pk(636, 3, 232, 247, 0));
    charSize = 3'd1;
    tick();
    check("grow_clamp", got(0), pk(624, 639, 232, 263, 0));
    check("grow_wrap",  got(1), pk(636, 11, 232, 263, 0));
    check("grow_fine",  got(2), pk(624, 639, 232, 263, 0));
    charSize = 3'd0;

    // Held Up: moves at ticks 1, 31, 35, 39.
    do_reset();
    set_lvl(4'b0001);
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (t == 30) begin
        check("hold30_clamp", got(0), pk(316, 323, 216, 231, 0));
        check("hold30_fine",  got(2), pk(316, 323, 231, 246, 0));
      end
      if (t == 31) begin
        check("hold31_clamp", got(0), pk(316, 323, 200, 215, 0));
        check("hold31_fine",  got(2), pk(316, 323, 230, 245, 0));
      end
    end
    check("hold40_clamp", got(0), pk(316, 323, 168, 183, 0));
    check("hold40_wrap",  got(1), pk(316, 323, 168, 183, 0));
    check("hold40_fine",  got(2), pk(316, 323, 228, 243, 0));

    // Asynchronous reset while Up is held; the held button must not count as a press.
    set_lvl(4'b0000);
    do_reset();
    set_lvl(4'b0001);
    repeat (20) tick();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset_clamp", got(0), pk(316, 323, 232, 247, 0));
    check("async_reset_fine",  got(2), pk(316, 323, 232, 247, 0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    repeat (40) tick();
    check("held_after_reset_clamp", got(0), pk(316, 323, 232, 247, 0));
    check("held_after_reset_fine",  got(2), pk(316, 323, 232, 247, 0));
    set_lvl(4'b0000);
    set_lvl(4'b0001);
    tick();
    check("repress_clamp", got(0), pk(316, 323, 216, 231, 0));
    check("repress_fine",  got(2), pk(316, 323, 231, 246, 0));

    // Random frames against the reference model.
    set_lvl(4'b0000);
    charSize = 3'd0;
    do_reset();
    model_init();
    for (int f = 0; f < 500; f++) begin
      logic [3:0] nl;
      nl = m_lvl;
      for (int d = 0; d < 4; d++) if ($urandom_range(0, 13) == 0) nl[d] = ~nl[d];
      set_lvl(nl);
      model_level(nl);
      if ($urandom_range(0, 3) == 0) begin
        nl = nl ^ 4'($urandom_range(0, 15));
        set_lvl(nl);
        model_level(nl);
      end
      if ($urandom_range(0, 11) == 0) begin
        pulse_center();
        m_ctr = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) charSize = 3'($urandom_range(0, 7));
      tick();
      model_tick();
      for (int i = 0; i < 3; i++)
        check($sformatf("rand%0d_dut%0d", f, i), got(i), pk(m[i].x, m[i].ex, m[i].y, m[i].ey, m[i].hit));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
